softmax_topk: RTL



---
 rtl/softmax_pkg.sv | 9 +
 rtl/topk_insert.sv | 33 +++
 rtl/softmax_topk.sv | 105 ++++++++++
 3 files changed

// File: rtl/softmax_pkg.sv
// softmax_pkg: shared defaults, rank width and FSM encoding for the softmax top-K selector.
package softmax_pkg;
  localparam int D_WORDLENGTH = 8;
  localparam int D_IDXWIDTH = 8;
  localparam int D_VECTOR_LEN = 256;
  localparam int D_K = 5;
  localparam int RANKW = 3;
  typedef enum logic {COLLECT = 1'b0, OUTPUT = 1'b1} state_t;
endpackage

// File: rtl/topk_insert.sv
// topk_insert: combinational single-step insertion of a new pair into a descending sorted K-slot list.
module topk_insert #(
  parameter int W = 8,
  parameter int IW = 8,
  parameter int N = 5
)(
  input  logic [N-1:0][W-1:0]  val_i,
  input  logic [N-1:0][IW-1:0] idx_i,
  input  logic [N-1:0]         vld_i,
  input  logic [W-1:0]         din,
  input  logic [IW-1:0]        iin,
  output logic [N-1:0][W-1:0]  val_o,
  output logic [N-1:0][IW-1:0] idx_o,
  output logic [N-1:0]         vld_o
);
  logic [N-1:0] ins;
  logic [N:0] pre;
  assign pre[0] = 1'b0;
  for (genvar j = 0; j < N; j++) begin : g
    // strict compare keeps an equal earlier arrival ahead of the new one
    assign ins[j] = !vld_i[j] || din > val_i[j];
    assign pre[j+1] = pre[j] | ins[j];
    if (j == 0) begin : g_head
      assign val_o[j] = ins[j] ? din : val_i[j];
      assign idx_o[j] = ins[j] ? iin : idx_i[j];
      assign vld_o[j] = ins[j] | vld_i[j];
    end else begin : g_tail
      assign val_o[j] = pre[j] ? val_i[j-1] : ins[j] ? din : val_i[j];
      assign idx_o[j] = pre[j] ? idx_i[j-1] : ins[j] ? iin : idx_i[j];
      assign vld_o[j] = pre[j] ? vld_i[j-1] : ins[j] | vld_i[j];
    end
  end
endmodule

// File: rtl/softmax_topk.sv
// softmax_topk: streaming top-K selector over a frame of softmax probabilities, emitting winners in rank order.
module softmax_topk import softmax_pkg::*; #(
  parameter int WORDLENGTH = D_WORDLENGTH,
  parameter int IDXWIDTH = D_IDXWIDTH,
  parameter int VECTOR_LEN = D_VECTOR_LEN,
  parameter int K = D_K
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  in_en,
  input  logic [WORDLENGTH-1:0] in_data,
  input  logic [IDXWIDTH-1:0]   in_idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORDLENGTH-1:0] out_data,
  output logic [IDXWIDTH-1:0]   out_idx,
  output logic [RANKW-1:0]      out_rank,
  output logic                  out_last,
  output logic                  busy,
  output logic                  overrun
);
  localparam int CW = VECTOR_LEN > 1 ? $clog2(VECTOR_LEN) : 1;
  state_t st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [RANKW-1:0] rp, rp_n;
  logic [K-1:0][WORDLENGTH-1:0] val, val_n, ins_val;
  logic [K-1:0][IDXWIDTH-1:0] idx, idx_n, ins_idx;
  logic [K-1:0] vld, vld_n, ins_vld;
  logic ovr_n, term;
  topk_insert #(.W(WORDLENGTH), .IW(IDXWIDTH), .N(K)) u_ins (
    .val_i(val), .idx_i(idx), .vld_i(vld), .din(in_data), .iin(in_idx),
    .val_o(ins_val), .idx_o(ins_idx), .vld_o(ins_vld)
  );
  assign term = cnt == CW'(VECTOR_LEN - 1);
  assign busy = st == OUTPUT;
  always_comb begin
    st_n = st;
    cnt_n = cnt;
    rp_n = rp;
    val_n = val;
    idx_n = idx;
    vld_n = vld;
    ovr_n = 1'b0;
    if (clr) begin
      st_n = COLLECT;
      cnt_n = '0;
      rp_n = '0;
      val_n = '0;
      idx_n = '0;
      vld_n = '0;
    end else if (st == COLLECT) begin
      if (in_en) begin
        val_n = ins_val;
        idx_n = ins_idx;
        vld_n = ins_vld;
        cnt_n = term ? '0 : cnt + 1'b1;
        st_n = term ? OUTPUT : COLLECT;
      end
    end else begin
      ovr_n = in_en;
      if (out_valid && out_ready) begin
        if (rp == RANKW'(K - 1)) begin
          st_n = COLLECT;
          rp_n = '0;
          val_n = '0;
          idx_n = '0;
          vld_n = '0;
        end else begin
          rp_n = rp + 1'b1;
        end
      end
    end
  end
  // output register loads from next-state values so rank 0 is visible on the first OUTPUT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= COLLECT;
      cnt <= '0;
      rp <= '0;
      val <= '0;
      idx <= '0;
      vld <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_idx <= '0;
      out_rank <= '0;
      out_last <= 1'b0;
      overrun <= 1'b0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      rp <= rp_n;
      val <= val_n;
      idx <= idx_n;
      vld <= vld_n;
      out_valid <= st_n == OUTPUT;
      out_data <= st_n == OUTPUT ? val_n[rp_n] : '0;
      out_idx <= st_n == OUTPUT ? idx_n[rp_n] : '0;
      out_rank <= st_n == OUTPUT ? rp_n : '0;
      out_last <= st_n == OUTPUT && rp_n == RANKW'(K - 1);
      overrun <= ovr_n;
    end
  end
endmodule
